inst_mem_ctrl: RTL and testbench
================================

// Module: inst_mem_ctrl
// PURPOSE
//  Parametrised successor to the single-port instruction RAM.
//  Provides byte-enabled writes from the program loader and a ready/valid fetch port for the CPU front end.
//  Clears all of memory after reset.
//  Holds read data stable under back-pressure. Optionally checks per-byte parity on reads.
//  Sits between the loader/debug bus and the fetch stage of the RISC core.
// PARAMETERS
//  DW     32    data word width; must be a multiple of 8
//  AW     13    address width, in words
//  DEPTH  8192  words implemented; DEPTH <= 2**AW
// PORTS
//  clka       in   1      clock; all logic rising-edge
//  rsta_n     in   1      asynchronous reset, active-low
//  init_done  out  1      1 once the post-reset clear sweep has completed
//  wr_en      in   1      write strobe, loader side
//  wr_addr    in   AW     write word address
//  wr_data    in   DW     write data
//  wr_be      in   DW/8   byte enables; bit i covers wr_data[8i+7:8i]
//  rd_req     in   1      fetch request
//  rd_addr    in   AW     fetch word address
//  rd_gnt     out  1      request accepted this cycle (combinational)
//  rd_valid   out  1      rd_data/rd_err valid
//  rd_ready   in   1      consumer takes rd_data this cycle
//  rd_data    out  DW     fetched word
//  rd_err     out  1      parity error on rd_data; tied 0 without the macro
// BEHAVIOUR
//  Reset: state=CLEAR, clr_cnt=0, init_done=0, rd_valid=0, rd_data=0, rd_err=0.
//  FSM CLEAR
//   - One word per cycle: writes 0 (with correct parity) at clr_cnt, clr_cnt++.
//   - wr_en is ignored; rd_gnt=0.
//   - After word DEPTH-1 -> RUN next cycle; init_done=1 from that edge.
//   - The sweep takes exactly DEPTH cycles.
//  FSM RUN
//   - RUN is permanent until reset.
//   - rsta_n low mid-operation: immediate return to CLEAR; in-flight read dropped; memory re-cleared.
//  Write (RUN)
//   - wr_en=1 writes the wr_be-selected bytes at wr_addr on that edge.
//   - wr_addr >= DEPTH: write silently dropped.
//   - wr_be=0: no-op.
//  Fetch (RUN)
//   - rd_gnt = (state==RUN) && (!rd_valid || rd_ready).
//   - rd_req && rd_gnt: rd_data is valid on the next edge (latency 1), rd_valid=1.
//   - rd_valid && !rd_ready: rd_data, rd_err and rd_valid hold; no new array read issued (stall).
//   - rd_valid && rd_ready && !rd_req: rd_valid drops to 0 next edge.
//   - Back-to-back: rd_req held with rd_ready=1 gives one word per cycle.
//   - rd_addr >= DEPTH: returns rd_data=0, rd_err=0.
//  Collisions
//   - Same-cycle write and granted read at the same address: write-first.
//   - rd_data = new bytes where wr_be=1, old bytes elsewhere.
//   - A write to the address of a word held under stall does not alter the held rd_data.
// CONFIGURATION
//  INST_MEM_PARITY_EN defined
//   - Array stores one even-parity bit per byte (DW + DW/8 bits per word).
//   - Parity is generated on write and clear, and checked on read.
//   - rd_err=1 with rd_valid if any byte mismatches; rd_err is held under stall like rd_data.
//   - Data is still returned unmodified.
//  INST_MEM_PARITY_EN undefined
//   - Array is DW bits wide; rd_err is constant 0; no parity logic.
// STRUCTURE
//  Package inst_mem_pkg:
//   - state enum {CLEAR, RUN}
//   - default DW/AW/DEPTH constants
//   - function be_w(DW) = DW/8
//   - function byte_parity(word) returning DW/8 bits
//  Sub-module inst_mem_array:
//   - Plain storage; one write port with byte enables, one synchronous read port with read enable.
//   - Not reset; inferable as block RAM.
//  inst_mem_ctrl holds:
//   - FSM and clr_cnt
//   - write mux (clear vs loader)
//   - bypass/collision logic
//   - output hold register and parity check
// TESTING
//  1. Reset, then idle.
//     -> init_done=0 for exactly DEPTH cycles, then 1.
//     -> Reads of addr 0, 0x100 and DEPTH-1 return 0x00000000.
//  2. Write 0xDEADBEEF @0x010 (be=4'hF), then write 0x000000AA @0x010 with be=4'h1.
//     -> Fetch @0x010 returns 0xDEADBEAA one cycle after grant.
//  3. Fetch @0x020 (data 0x11111111), then hold rd_ready=0 for 5 cycles while writing 0x22222222 @0x020.
//     -> rd_data stays 0x11111111 and rd_gnt=0 throughout the stall.
//     -> After the stall, a re-fetch returns 0x22222222.
//  4. Same cycle: write 0xCAFEF00D @0x030 with be=4'hC, and fetch @0x030 (old value 0x12345678).
//     -> rd_data = 0xCAFE5678.
//  5. Stream fetches @0..7 with rd_ready=1.
//     -> 8 consecutive rd_valid cycles, data in order.
//     -> Assert rsta_n low mid-stream: rd_valid=0 immediately; init_done returns to 0.
//     -> After the new sweep, reads return 0.
//  6. With INST_MEM_PARITY_EN: force one stored data bit flipped @0x040.
//     -> Fetch @0x040 gives rd_err=1, held while stalled.
//     -> Other addresses give rd_err=0.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction memory controller.
// Parity storage is enabled by defining INST_MEM_PARITY_EN.
package inst_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 13;
  localparam int DEF_DEPTH = 8192;

  // Widest word the parity helper handles; narrower words are zero-extended.
  localparam int MAX_DW = 512;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

  // Even parity per byte: stored bit makes each 9-bit lane hold an even count of ones.
  function automatic logic [MAX_BE-1:0] byte_parity(input logic [MAX_DW-1:0] word);
    logic [MAX_BE-1:0] p;
    for (int i = 0; i < MAX_BE; i++) begin
      p[i] = ^word[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/inst_mem_if.sv
// Loader write port and CPU fetch port of the instruction memory.
interface inst_mem_if #(
  parameter int DW = 32,
  parameter int AW = 13
) ();

  // Handshakes: a fetch is accepted on a rising edge where rd_req && rd_gnt;
  // a returned word is consumed on an edge where rd_valid && rd_ready.
  // rd_valid never depends on rd_ready; rd_data/rd_err hold while rd_valid && !rd_ready.
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_be;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_gnt;
  logic            rd_valid;
  logic            rd_ready;
  logic [DW-1:0]   rd_data;
  logic            rd_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr, rd_ready,
    input  rd_gnt, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr, rd_ready,
    output rd_gnt, rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/inst_mem_array.sv
// Byte-lane storage array: one masked write port, one registered read port.
// No reset so it maps onto block RAM; read returns the pre-write contents.
module inst_mem_array #(
  parameter int NB    = 4,
  parameter int LW    = 8,
  parameter int AW    = 13,
  parameter int DEPTH = 8192
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NB-1:0]    wbe,
  input  logic [NB*LW-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [NB*LW-1:0] rdata
);

  logic [NB*LW-1:0] mem [DEPTH];
  logic [NB*LW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
        end
      end
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: post-reset clear sweep, byte-enabled loader writes,
// ready/valid fetch with write-first bypass. Per-byte parity when INST_MEM_PARITY_EN is defined.
module inst_mem_ctrl
  import inst_mem_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic      clka,
  input  logic      rsta_n,
  output logic      init_done,
  output state_t    dbg_state,
  inst_mem_if.slave bus
);

  localparam int BE = be_w(DW);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INST_MEM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int WW = BE * LW;
  localparam logic [IW-1:0] CLR_LAST = IW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic            oob_q, oob_d;
  logic            byp_q, byp_d;
  logic [WW-1:0]   byp_word_q, byp_word_d;
  logic [BE-1:0]   byp_be_q, byp_be_d;

  logic            arr_we, arr_re;
  logic [IW-1:0]   arr_waddr;
  logic [BE-1:0]   arr_wbe;
  logic [WW-1:0]   arr_wdata, arr_rdata;
  logic            wr_in_range, rd_in_range, wr_hit, rd_take;
  logic [WW-1:0]   out_word;
  logic [DW-1:0]   out_data;

  // Lane i of a stored word is {parity_i, byte_i} with parity, or just byte_i without.
  function automatic logic [WW-1:0] pack_word(input logic [DW-1:0] d);
    logic [WW-1:0] w;
`ifdef INST_MEM_PARITY_EN
    logic [BE-1:0] p;
    p = BE'(byte_parity(MAX_DW'(d)));
`endif
    w = '0;
    for (int i = 0; i < BE; i++) begin
      w[i*LW +: 8] = d[i*8 +: 8];
`ifdef INST_MEM_PARITY_EN
      w[i*LW + 8] = p[i];
`endif
    end
    return w;
  endfunction

  assign wr_in_range = 32'(bus.wr_addr) < DEPTH;
  assign rd_in_range = 32'(bus.rd_addr) < DEPTH;
  assign wr_hit      = (state_q == RUN) && bus.wr_en && wr_in_range && (|bus.wr_be);
  assign bus.rd_gnt  = (state_q == RUN) && (!rd_valid_q || bus.rd_ready);
  assign rd_take     = bus.rd_req && bus.rd_gnt;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // The sweep owns the write port while clearing; loader writes are ignored then.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = clr_cnt_q;
    arr_wbe   = '1;
    arr_wdata = pack_word('0);
    if (state_q == CLEAR) begin
      arr_we = 1'b1;
    end else if (wr_hit) begin
      arr_we    = 1'b1;
      arr_waddr = bus.wr_addr[IW-1:0];
      arr_wbe   = bus.wr_be;
      arr_wdata = pack_word(bus.wr_data);
    end
  end

  // Array reads return old data, so a same-edge write is captured here and merged at the output.
  always_comb begin
    rd_valid_d = rd_valid_q;
    oob_d      = oob_q;
    byp_d      = byp_q;
    byp_word_d = byp_word_q;
    byp_be_d   = byp_be_q;
    arr_re     = 1'b0;
    if (rd_take) begin
      rd_valid_d = 1'b1;
      oob_d      = !rd_in_range;
      arr_re     = rd_in_range;
      byp_d      = wr_hit && (bus.wr_addr == bus.rd_addr);
      byp_word_d = arr_wdata;
      byp_be_d   = bus.wr_be;
    end else if (rd_valid_q && bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_word = '0;
    out_data = '0;
    for (int i = 0; i < BE; i++) begin
      out_word[i*LW +: LW] = (byp_q && byp_be_q[i]) ? byp_word_q[i*LW +: LW]
                                                    : arr_rdata[i*LW +: LW];
    end
    for (int i = 0; i < BE; i++) begin
      out_data[i*8 +: 8] = out_word[i*LW +: 8];
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = (rd_valid_q && !oob_q) ? out_data : '0;

`ifdef INST_MEM_PARITY_EN
  logic [BE-1:0] out_par;
  always_comb begin
    out_par = '0;
    for (int i = 0; i < BE; i++) begin
      out_par[i] = out_word[i*LW + 8];
    end
  end
  assign bus.rd_err = rd_valid_q && !oob_q && (BE'(byte_parity(MAX_DW'(out_data))) != out_par);
`else
  assign bus.rd_err = 1'b0;
`endif

  assign init_done = (state_q == RUN);
  assign dbg_state = state_q;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_word_q <= '0;
      byp_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_valid_q <= rd_valid_d;
      oob_q      <= oob_d;
      byp_q      <= byp_d;
      byp_word_q <= byp_word_d;
      byp_be_q   <= byp_be_d;
    end
  end

  inst_mem_array #(
    .NB    (BE),
    .LW    (LW),
    .AW    (IW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clka),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wbe   (arr_wbe),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (bus.rd_addr[IW-1:0]),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: vector table plus directed stall, collision, stream and reset sequences.
// Parity corruption checks are compiled in when INST_MEM_PARITY_EN is defined.
module tb_inst_mem_ctrl;
  import inst_mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 4096;
  localparam int W     = DW + 1;

  logic   clka = 1'b0;
  logic   rsta_n = 1'b0;
  logic   init_done;
  state_t dbg_state;

  inst_mem_if #(.DW(DW), .AW(AW)) bus_if ();

  inst_mem_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .init_done (init_done),
    .dbg_state (dbg_state),
    .bus       (bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic ready_rand = 1'b0;
  int last_gnt_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clka) begin
    if (rsta_n && bus_if.rd_valid && bus_if.rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected word queued",
                 {bus_if.rd_err, bus_if.rd_data});
      end else begin
        check("rd_word", {bus_if.rd_err, bus_if.rd_data}, exp_q.pop_front());
      end
    end
  end

  always @(posedge clka) begin
    if (ready_rand) begin
      #1 bus_if.rd_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [3:0] be);
    if (32'(a) < DEPTH) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_m[a[11:0]][i*8 +: 8] = d[i*8 +: 8];
      end
    end
  endfunction

  function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
    if (32'(a) < DEPTH) return {1'b0, mem_m[a[11:0]]};
    return '0;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;
    bus_if.wr_be   = '0;
    bus_if.rd_req  = 1'b0;
    bus_if.rd_addr = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    @(posedge clka); #1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    bus_if.wr_be   = be;
    model_write(a, d, be);
    @(posedge clka); #1;
    bus_if.wr_en = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [W-1:0] exp);
    int n = 0;
    logic ok = 1'b1;
    @(posedge clka); #1;
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = a;
    forever begin
      @(negedge clka);
      if (bus_if.rd_gnt) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL fetch_grant_timeout: addr 0x%0h got no grant, required one within 50 cycles", a);
        ok = 1'b0;
        break;
      end
      @(posedge clka); #1;
    end
    if (ok) begin
      exp_q.push_back(exp);
      last_gnt_cyc = cyc;
    end
  endtask

  task automatic rd_idle();
    @(posedge clka); #1;
    bus_if.rd_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clka);
      n++;
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    forever begin
      @(posedge clka); #1;
      n++;
      if (n == DEPTH / 2) check({name, "_gnt_in_clear"}, 64'(bus_if.rd_gnt), 0);
      if (init_done || n > DEPTH + 20) break;
    end
    check({name, "_cycles"}, 64'(n), 64'(DEPTH));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    be;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int first_gnt;

    vecs[0]  = '{1'b0, 13'h0000, 32'h0,        4'h0, 32'h00000000};
    vecs[1]  = '{1'b0, 13'h0100, 32'h0,        4'h0, 32'h00000000};
    vecs[2]  = '{1'b0, 13'h0FFF, 32'h0,        4'h0, 32'h00000000};
    vecs[3]  = '{1'b1, 13'h0010, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[4]  = '{1'b1, 13'h0010, 32'h000000AA, 4'h1, 32'h0};
    vecs[5]  = '{1'b0, 13'h0010, 32'h0,        4'h0, 32'hDEADBEAA};
    vecs[6]  = '{1'b1, 13'h0FFF, 32'hA5A5A5A5, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, 13'h0FFF, 32'h0,        4'h0, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 13'h0011, 32'h01020304, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 13'h0011, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[10] = '{1'b0, 13'h0011, 32'h0,        4'h0, 32'h01020304};
    vecs[11] = '{1'b1, 13'h1012, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[12] = '{1'b0, 13'h0012, 32'h0,        4'h0, 32'h00000000};
    vecs[13] = '{1'b0, 13'h1012, 32'h0,        4'h0, 32'h00000000};
    vecs[14] = '{1'b1, 13'h0013, 32'h11223344, 4'hF, 32'h0};
    vecs[15] = '{1'b1, 13'h0013, 32'hAABBCCDD, 4'h6, 32'h0};
    vecs[16] = '{1'b0, 13'h0013, 32'h0,        4'h0, 32'h11BBCC44};

    // Reset with loader traffic present; it must not land during the sweep.
    idle();
    bus_if.rd_ready = 1'b1;
    bus_if.wr_en    = 1'b1;
    bus_if.wr_addr  = 13'h0000;
    bus_if.wr_data  = 32'hFFFFFFFF;
    bus_if.wr_be    = 4'hF;
    bus_if.rd_req   = 1'b1;
    model_clear();
    repeat (3) @(posedge clka);
    #1;
    check("rst_init_done", 64'(init_done), 0);
    check("rst_rd_valid", 64'(bus_if.rd_valid), 0);
    check("rst_rd_data", 64'(bus_if.rd_data), 0);
    check("rst_rd_err", 64'(bus_if.rd_err), 0);
    check("rst_rd_gnt", 64'(bus_if.rd_gnt), 0);
    check("rst_state", 64'(dbg_state), 64'(CLEAR));
    @(negedge clka);
    rsta_n = 1'b1;
    wait_init("init");
    idle();
    check("state_run", 64'(dbg_state), 64'(RUN));

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].be);
      end else begin
        fetch(vecs[i].addr, {1'b0, vecs[i].exp});
        rd_idle();
        check("rd_latency", 64'(bus_if.rd_valid), 1);
      end
    end
    drain();

    // Stall: held word survives a write to its own address.
    wr(13'h020, 32'h11111111, 4'hF);
    fetch(13'h020, {1'b0, 32'h11111111});
    @(posedge clka); #1;
    bus_if.rd_ready = 1'b0;
    bus_if.rd_addr  = 13'h020;
    bus_if.wr_en    = 1'b1;
    bus_if.wr_addr  = 13'h020;
    bus_if.wr_data  = 32'h22222222;
    bus_if.wr_be    = 4'hF;
    model_write(13'h020, 32'h22222222, 4'hF);
    for (int s = 0; s < 5; s++) begin
      @(negedge clka);
      check("stall_rd_data", 64'(bus_if.rd_data), 64'h11111111);
      check("stall_rd_gnt", 64'(bus_if.rd_gnt), 0);
      check("stall_rd_valid", 64'(bus_if.rd_valid), 1);
      @(posedge clka); #1;
      bus_if.wr_en = 1'b0;
      if (s == 4) begin
        bus_if.rd_req   = 1'b0;
        bus_if.rd_ready = 1'b1;
      end
    end
    fetch(13'h020, {1'b0, 32'h22222222});
    rd_idle();
    drain();

    // Same-edge write and fetch: written bytes come back, others are old.
    wr(13'h030, 32'h12345678, 4'hF);
    @(posedge clka); #1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 13'h030;
    bus_if.wr_data = 32'hCAFEF00D;
    bus_if.wr_be   = 4'hC;
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = 13'h030;
    model_write(13'h030, 32'hCAFEF00D, 4'hC);
    @(negedge clka);
    check("collide_gnt", 64'(bus_if.rd_gnt), 1);
    if (bus_if.rd_gnt) exp_q.push_back({1'b0, 32'hCAFE5678});
    @(posedge clka); #1;
    idle();
    fetch(13'h030, {1'b0, 32'hCAFE5678});
    rd_idle();
    drain();

    // Random writes, then reads under random back-pressure.
    for (int k = 0; k < 24; k++) begin
      wr(13'h200 + 13'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end
    ready_rand = 1'b1;
    for (int k = 0; k < 16; k++) begin
      fetch(13'h200 + 13'(k), model_read(13'h200 + 13'(k)));
    end
    rd_idle();
    drain();
    ready_rand = 1'b0;
    @(negedge clka);
    bus_if.rd_ready = 1'b1;

    // Back-to-back stream of eight words.
    for (int i = 0; i < 8; i++) wr(13'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
    for (int i = 0; i < 8; i++) begin
      fetch(13'(i), model_read(13'(i)));
      if (i == 0) first_gnt = last_gnt_cyc;
    end
    rd_idle();
    check("stream_span", 64'(last_gnt_cyc - first_gnt), 7);
    drain();

`ifdef INST_MEM_PARITY_EN
    wr(13'h040, 32'h0F0F0F0F, 4'hF);
    wr(13'h041, 32'h0F0F0F0F, 4'hF);
    dut.u_array.mem[12'h040][0] = ~dut.u_array.mem[12'h040][0];
    fetch(13'h040, {1'b1, 32'h0F0F0F0E});
    @(posedge clka); #1;
    bus_if.rd_req   = 1'b0;
    bus_if.rd_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clka);
      check("par_err_hold", 64'(bus_if.rd_err), 1);
      check("par_data_hold", 64'(bus_if.rd_data), 64'h0F0F0F0E);
    end
    @(posedge clka); #1;
    bus_if.rd_ready = 1'b1;
    fetch(13'h041, {1'b0, 32'h0F0F0F0F});
    rd_idle();
    drain();
`endif

    // Reset in the middle of a stream drops the in-flight word and re-clears memory.
    for (int i = 0; i < 4; i++) fetch(13'(i), model_read(13'(i)));
    @(posedge clka); #1;
    check("prerst_rd_valid", 64'(bus_if.rd_valid), 1);
    rsta_n = 1'b0;
    #1;
    check("midrst_rd_valid", 64'(bus_if.rd_valid), 0);
    check("midrst_init_done", 64'(init_done), 0);
    check("midrst_rd_data", 64'(bus_if.rd_data), 0);
    check("midrst_inflight", 64'(exp_q.size()), 1);
    exp_q.delete();
    idle();
    model_clear();
    repeat (2) @(posedge clka);
    @(negedge clka);
    rsta_n = 1'b1;
    wait_init("reinit");
    for (int i = 0; i < 8; i++) fetch(13'(i), model_read(13'(i)));
    rd_idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
